// File: rtl/sfq_word_transmitter.sv
// sfq_word_transmitter: serialises words into SFQ data-pulse / clock-pulse pairs for clocked gates
module sfq_word_transmitter #(
  parameter int WIDTH = 8,
  parameter int SETUP_CYC = 2,
  parameter int GAP_CYC = 1,
  parameter bit LSB_FIRST = 1
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             data_pulse,
  output logic             clk_pulse,
  output logic             busy,
  output logic [4:0]       bit_idx,
  output logic             frame_done
);
  typedef enum logic [2:0] {IDLE, DATA, SETUP, CLK, GAP} state_t;
  state_t state, nxt, after_clk;
  logic [3:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sh, src;
  logic [5:0] idx;
  logic acc, last, cur;
  assign acc = word_valid & word_ready;
  assign last = idx == 6'(WIDTH);
  assign src = acc ? word_in : sh;
  assign cur = LSB_FIRST ? src[0] : src[WIDTH-1];
  assign bit_idx = idx[4:0];
  // idx already counts the bit being clocked, so CLK and GAP share one exit decision
  always_comb begin
    nxt = state;
    cnt_nxt = cnt - 4'd1;
    after_clk = last ? IDLE : DATA;
    case (state)
      IDLE:  nxt = acc ? DATA : IDLE;
      DATA: begin
        nxt = SETUP_CYC > 0 ? SETUP : CLK;
        cnt_nxt = 4'(SETUP_CYC - 1);
      end
      SETUP: nxt = cnt == 4'd0 ? CLK : SETUP;
      CLK: begin
        nxt = GAP_CYC > 0 ? GAP : after_clk;
        cnt_nxt = 4'(GAP_CYC - 1);
      end
      GAP:   nxt = cnt == 4'd0 ? after_clk : GAP;
      default: nxt = IDLE;
    endcase
  end
  // outputs are decoded from the next state so pulses line up with the state they belong to
  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      idx <= '0;
      data_pulse <= 1'b0;
      clk_pulse <= 1'b0;
      frame_done <= 1'b0;
      busy <= 1'b0;
      word_ready <= 1'b1;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      sh <= acc ? word_in : nxt == CLK ? (LSB_FIRST ? sh >> 1 : sh << 1) : sh;
      idx <= nxt == IDLE ? 6'd0 : nxt == CLK ? idx + 6'd1 : idx;
      data_pulse <= nxt == DATA && cur;
      clk_pulse <= nxt == CLK;
      frame_done <= nxt == IDLE && state != IDLE;
      busy <= nxt != IDLE;
      word_ready <= nxt == IDLE;
    end
  end
endmodule
